// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared pipeline widths, counter encodings and default reset PC
package fetch_stage_pkg;
  localparam int PC_W = 32;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT = 2'b10;
  localparam ctr_t CTR_ST = 2'b11;
endpackage

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped BTB with 2-bit counters, word-addressed lookup and training ports
module btb_predictor
  import fetch_stage_pkg::*;
#(
  parameter int BTB_ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] lk_wa_i,
  output logic        lk_hit_o,
  output logic        lk_taken_o,
  output logic [29:0] lk_tgt_o,
  input  logic        upd_valid_i,
  input  logic [29:0] upd_wa_i,
  input  logic        upd_taken_i,
  input  logic [29:0] upd_tgt_i
);
  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX;
  logic             valid_q [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q [BTB_ENTRIES];
  logic [29:0]      tgt_q [BTB_ENTRIES];
  ctr_t             ctr_q [BTB_ENTRIES];
  logic [IDX-1:0]   li, ui;
  logic [TAG_W-1:0] lt, ut;
  logic             u_hit;
  ctr_t             ctr_d;
  always_comb begin
    li = lk_wa_i[IDX-1:0];
    lt = lk_wa_i[29:IDX];
    ui = upd_wa_i[IDX-1:0];
    ut = upd_wa_i[29:IDX];
    lk_hit_o = valid_q[li] && tag_q[li] == lt;
    lk_taken_o = lk_hit_o && ctr_q[li][1];
    lk_tgt_o = tgt_q[li];
    u_hit = valid_q[ui] && tag_q[ui] == ut;
    ctr_d = !u_hit ? CTR_WT
          : upd_taken_i ? (ctr_q[ui] == CTR_ST ? CTR_ST : ctr_q[ui] + 2'd1)
          : (ctr_q[ui] == CTR_SNT ? CTR_SNT : ctr_q[ui] - 2'd1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i] <= CTR_WNT;
      end
    end else if (upd_valid_i && (u_hit || upd_taken_i)) begin
      valid_q[ui] <= 1'b1;
      tag_q[ui] <= ut;
      ctr_q[ui] <= ctr_d;
      if (upd_taken_i) tgt_q[ui] <= upd_tgt_i;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection and BTB-predicted fetch feeding IF/ID
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int BTB_ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_out,
  output logic [31:0] pc4_out,
  output logic        prediction_out
);
  logic [31:0] pc_q, pc_d;
  logic        hit, taken;
  logic [29:0] tgt;
  logic        unused_bits;
  assign unused_bits = ^{redirect_pc[1:0], upd_pc[1:0], upd_target[1:0], hit};
  btb_predictor #(.BTB_ENTRIES(BTB_ENTRIES)) u_btb (
    .clk         (clk),
    .rst         (rst),
    .lk_wa_i     (pc_q[31:2]),
    .lk_hit_o    (hit),
    .lk_taken_o  (taken),
    .lk_tgt_o    (tgt),
    .upd_valid_i (upd_valid),
    .upd_wa_i    (upd_pc[31:2]),
    .upd_taken_i (upd_taken),
    .upd_tgt_i   (upd_target[31:2])
  );
  always_comb begin
    pc_out = pc_q;
    imem_addr = pc_q;
    pc4_out = pc_q + 32'd4;
    prediction_out = taken;
    pc_d = redirect_valid ? {redirect_pc[31:2], 2'b00}
         : !en ? pc_q
         : taken ? {tgt, 2'b00}
         : pc4_out;
  end
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage
module tb_fetch_stage;
  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic [31:0] imem_addr, pc_out, pc4_out;
  logic        prediction_out;
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .imem_addr      (imem_addr),
    .pc_out         (pc_out),
    .pc4_out        (pc4_out),
    .prediction_out (prediction_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] epc, input logic epred);
    logic [31:0] e4;
    e4 = epc + 32'd4;
    checks += 4;
    assert (pc_out === epc) else begin errors++; $error("FAIL %s pc_out got %h exp %h", tag, pc_out, epc); end
    assert (imem_addr === epc) else begin errors++; $error("FAIL %s imem_addr got %h exp %h", tag, imem_addr, epc); end
    assert (pc4_out === e4) else begin errors++; $error("FAIL %s pc4_out got %h exp %h", tag, pc4_out, e4); end
    assert (prediction_out === epred) else begin errors++; $error("FAIL %s prediction_out got %b exp %b", tag, prediction_out, epred); end
  endtask
  task automatic drive(input logic r, input logic e, input logic rv, input logic [31:0] rpc,
                       input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utg);
    rst = r; en = e; redirect_valid = rv; redirect_pc = rpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
  endtask
  task automatic push(input logic [31:0] epc, input logic epred);
    exp_q.push_back('{pc: epc, pred: epred});
  endtask
  task automatic tick(input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      x = exp_q.pop_front();
      chk(tag, x.pc, x.pred);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0); push(32'h0, 0); tick("reset");
    drive(0, 1, 0, 0, 0, 0, 0, 0); push(32'h4, 0); tick("seq4");
    drive(0, 1, 0, 0, 0, 0, 0, 0); push(32'h8, 0); tick("seq8");
    drive(0, 0, 0, 0, 0, 0, 0, 0); push(32'h8, 0); tick("stall1");
    drive(0, 0, 0, 0, 0, 0, 0, 0); push(32'h8, 0); tick("stall2");
    drive(0, 1, 0, 0, 0, 0, 0, 0); push(32'hC, 0); tick("seqC");
    drive(0, 0, 1, 32'h103, 0, 0, 0, 0); push(32'h100, 0); tick("redir_stall");
    drive(0, 0, 0, 0, 1, 32'h10, 1, 32'h43); push(32'h100, 0); tick("alloc_hold");
    drive(0, 0, 1, 32'h10, 0, 0, 0, 0); push(32'h10, 1); tick("alloc_hit");
    drive(0, 1, 0, 0, 0, 0, 0, 0); push(32'h40, 0); tick("pred_target");
    drive(0, 0, 1, 32'h10, 0, 0, 0, 0); push(32'h10, 1); tick("back_to_10");
    drive(0, 0, 0, 0, 1, 32'h10, 0, 0); push(32'h10, 0); tick("nt1_wnt");
    drive(0, 0, 0, 0, 1, 32'h10, 0, 0); push(32'h10, 0); tick("nt2_snt");
    drive(0, 0, 0, 0, 1, 32'h10, 0, 0); push(32'h10, 0); tick("nt3_sat");
    drive(0, 1, 0, 0, 0, 0, 0, 0); push(32'h14, 0); tick("nt_fallthru");
    drive(0, 0, 1, 32'h10, 0, 0, 0, 0); push(32'h10, 0); tick("redir_10");
    drive(0, 0, 0, 0, 1, 32'h10, 1, 32'h40); push(32'h10, 0); tick("t1_wnt");
    drive(0, 0, 0, 0, 1, 32'h10, 1, 32'h40); push(32'h10, 1); tick("t2_wt");
    drive(0, 0, 0, 0, 1, 32'h10, 1, 32'h40); push(32'h10, 1); tick("t3_st");
    drive(0, 0, 0, 0, 1, 32'h10, 1, 32'h40); push(32'h10, 1); tick("t4_sat");
    drive(0, 0, 0, 0, 1, 32'h10, 0, 0); push(32'h10, 1); tick("st_nt_wt");
    drive(0, 0, 0, 0, 1, 32'h10, 0, 0); push(32'h10, 0); tick("wt_nt_wnt");
    drive(0, 0, 0, 0, 1, 32'h10, 1, 32'h40); push(32'h10, 1); tick("retrain_wt");
    drive(0, 1, 0, 0, 0, 0, 0, 0); push(32'h40, 0); tick("retrain_target");
    drive(0, 0, 0, 0, 1, 32'h40, 1, 32'h200);
    chk("same_cycle_old", 32'h40, 0);
    push(32'h40, 1); tick("same_cycle_new");
    drive(0, 0, 1, 32'h110, 0, 0, 0, 0); push(32'h110, 0); tick("alias_miss");
    drive(0, 0, 0, 0, 1, 32'h110, 1, 32'h300); push(32'h110, 1); tick("alias_alloc");
    drive(0, 0, 1, 32'h10, 0, 0, 0, 0); push(32'h10, 0); tick("alias_evicted");
    drive(0, 1, 0, 0, 0, 0, 0, 0); push(32'h14, 0); tick("alias_fallthru");
    drive(0, 0, 1, 32'h80, 1, 32'h80, 1, 32'h500); push(32'h80, 1); tick("redir_upd_same");
    drive(0, 1, 0, 0, 0, 0, 0, 0); push(32'h500, 0); tick("redir_upd_target");
    drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0); push(32'hFFFF_FFFC, 0); tick("wrap_pc");
    drive(0, 1, 0, 0, 0, 0, 0, 0); push(32'h0, 0); tick("wrap_next");
    drive(0, 1, 0, 0, 0, 0, 0, 0); push(32'h4, 0); tick("wrap_seq");
    drive(1, 1, 1, 32'h80, 1, 32'h10, 1, 32'h40); push(32'h0, 0); tick("rst_over_redir");
    drive(0, 0, 1, 32'h80, 0, 0, 0, 0); push(32'h80, 0); tick("rst_clear_80");
    drive(0, 0, 1, 32'h10, 0, 0, 0, 0); push(32'h10, 0); tick("rst_no_upd_10");
    drive(0, 0, 1, 32'h40, 0, 0, 0, 0); push(32'h40, 0); tick("rst_clear_40");
    drive(0, 0, 1, 32'h110, 0, 0, 0, 0); push(32'h110, 0); tick("rst_clear_110");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
